// File: rtl/source.sv
// -----------------------------------------------------------------------------
// source -- NoC traffic generator.
//
// Emits NUM_TESTS+2 flits (counter 0 .. NUM_TESTS+1) over a valid/ready
// handshake, then parks in FIN with done raised until the next reset.
// Flit layout, MSB first: {NODE, destination, ID, counter}.
//
// Ports:
//   clk       in   clock, all logic on the rising edge
//   rst       in   synchronous active-high reset
//   done      out  high once the last flit has been accepted
//   data_out  out  flit payload (WIDTH bits)
//   valid_out out  data_out is valid
//   ready_in  in   downstream accepts the flit this cycle
//
// All outputs are flops; ready_in only steers next-state logic.
// -----------------------------------------------------------------------------
module source #(
    parameter int                      WIDTH        = 32,
    parameter int                      N            = 16,
    parameter int                      N_ADDR_WIDTH = $clog2(N),
    parameter logic [7:0]              ID           = 8'd0,
    parameter logic [N_ADDR_WIDTH-1:0] NODE         = '0,
    parameter int                      DST_MODE     = 0,
    parameter logic [N_ADDR_WIDTH-1:0] DEST         = 15,
    parameter int                      INJ_GAP      = 0,
    parameter int                      NUM_TESTS    = 1000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    input  logic             ready_in
);

    localparam int D  = WIDTH - 2 * N_ADDR_WIDTH - 8;
    localparam int GW = (INJ_GAP > 1) ? $clog2(INJ_GAP) : 1;

    // Elaboration-time sanity checks on the configuration.
    if (D < 1) begin : g_chk_d
        $error("source: WIDTH too small for header fields");
    end
    if ((D < 63) && ((longint'(NUM_TESTS) + 1) >= (64'd1 << D))) begin : g_chk_cnt
        $error("source: NUM_TESTS+1 does not fit in the counter field");
    end
    if ((DST_MODE == 0) && (int'(DEST) >= N)) begin : g_chk_dest
        $error("source: DEST out of range");
    end

    localparam logic [D-1:0] LAST_CNT = D'(NUM_TESTS + 1);

    // First destination: fixed DEST, or the node right after ours (mod N).
    localparam logic [N_ADDR_WIDTH-1:0] DST_INIT =
        (DST_MODE != 0) ? ((int'(NODE) == N - 1) ? '0 : NODE + 1'b1) : DEST;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_FIN} state_t;

    state_t                  state_q, state_d;
    logic [D-1:0]            cnt_q, cnt_d;
    logic [N_ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;
    logic [WIDTH-1:0]        data_q, data_d;

    // Increment modulo N; handles non-power-of-two N.
    function automatic logic [N_ADDR_WIDTH-1:0] wrap_inc(input logic [N_ADDR_WIDTH-1:0] a);
        if (int'(a) == N - 1) return '0;
        return a + 1'b1;
    endfunction

    // Round-robin step skips our own node so we never address ourselves.
    function automatic logic [N_ADDR_WIDTH-1:0] next_dst(input logic [N_ADDR_WIDTH-1:0] a);
        logic [N_ADDR_WIDTH-1:0] n;
        n = wrap_inc(a);
        if (n == NODE) n = wrap_inc(n);
        return (DST_MODE != 0) ? n : DEST;
    endfunction

    function automatic logic [WIDTH-1:0] pack(input logic [D-1:0] c,
                                              input logic [N_ADDR_WIDTH-1:0] d);
        return {NODE, d, ID, c};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dst_d   = dst_q;
        gap_d   = gap_q;
        valid_d = valid_q;
        done_d  = done_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_SEND;
                valid_d = 1'b1;
                data_d  = pack(cnt_q, dst_q);
            end
            S_SEND: begin
                if (valid_q && ready_in) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_FIN;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        dst_d = next_dst(dst_q);
                        if (INJ_GAP == 0) begin
                            valid_d = 1'b1;
                            data_d  = pack(cnt_d, dst_d);
                        end else begin
                            // gap_q counts down to 0, giving INJ_GAP idle cycles.
                            state_d = S_GAP;
                            valid_d = 1'b0;
                            gap_d   = GW'(INJ_GAP - 1);
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_SEND;
                    valid_d = 1'b1;
                    data_d  = pack(cnt_q, dst_q);
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_FIN: begin
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset takes priority over any transfer presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dst_q   <= DST_INIT;
            gap_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dst_q   <= dst_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_source.sv
// -----------------------------------------------------------------------------
// tb_source -- four source instances with different configurations, driven
// with random ready/reset and compared each cycle against a flit-sequence
// reference model.
// -----------------------------------------------------------------------------
module tb_source;

    logic        clk = 1'b0;
    logic        rst_i [4];
    logic        rdy   [4];
    logic        vld   [4];
    logic        dne   [4];
    logic [31:0] dout  [4];

    always #5 clk = ~clk;

    // Configurations: A fixed dest, B fixed dest with gap, C round-robin from
    // node 15, D round-robin with N=5.
    int node_p [4] = '{3, 3, 15, 2};
    int n_p    [4] = '{16, 16, 16, 5};
    int naw_p  [4] = '{4, 4, 4, 3};
    int id_p   [4] = '{8'h05, 8'h05, 8'hA7, 8'h3C};
    int mode_p [4] = '{0, 0, 1, 1};
    int dest_p [4] = '{9, 9, 0, 0};
    int gap_p  [4] = '{0, 2, 0, 1};
    int nt_p   [4] = '{4, 4, 20, 10};

    source #(.WIDTH(32), .N(16), .ID(8'h05), .NODE(4'd3), .DST_MODE(0), .DEST(4'd9),
             .INJ_GAP(0), .NUM_TESTS(4)) u_a (
        .clk(clk), .rst(rst_i[0]), .done(dne[0]), .data_out(dout[0]),
        .valid_out(vld[0]), .ready_in(rdy[0]));
    source #(.WIDTH(32), .N(16), .ID(8'h05), .NODE(4'd3), .DST_MODE(0), .DEST(4'd9),
             .INJ_GAP(2), .NUM_TESTS(4)) u_b (
        .clk(clk), .rst(rst_i[1]), .done(dne[1]), .data_out(dout[1]),
        .valid_out(vld[1]), .ready_in(rdy[1]));
    source #(.WIDTH(32), .N(16), .ID(8'hA7), .NODE(4'd15), .DST_MODE(1), .DEST(4'd0),
             .INJ_GAP(0), .NUM_TESTS(20)) u_c (
        .clk(clk), .rst(rst_i[2]), .done(dne[2]), .data_out(dout[2]),
        .valid_out(vld[2]), .ready_in(rdy[2]));
    source #(.WIDTH(32), .N(5), .ID(8'h3C), .NODE(3'd2), .DST_MODE(1), .DEST(3'd0),
             .INJ_GAP(1), .NUM_TESTS(10)) u_d (
        .clk(clk), .rst(rst_i[3]), .done(dne[3]), .data_out(dout[3]),
        .valid_out(vld[3]), .ready_in(rdy[3]));

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: flit k goes to the k-th entry of the cyclic list of
    // nodes other than NODE (starting after NODE), or to DEST in fixed mode.
    function automatic logic [31:0] exp_flit(input int i, input int k);
        longint dst, w;
        if (mode_p[i] != 0) dst = (node_p[i] + 1 + (k % (n_p[i] - 1))) % n_p[i];
        else                dst = dest_p[i];
        w = (longint'(node_p[i]) << (32 - naw_p[i])) |
            (dst << (32 - 2 * naw_p[i])) |
            (longint'(id_p[i]) << (32 - 2 * naw_p[i] - 8)) | longint'(k);
        return w[31:0];
    endfunction

    // Model state: in reset/idle, next flit index, cycles since last
    // accepted flit, finished.
    bit m_rs  [4];
    int m_k   [4];
    int m_snc [4];
    bit m_fin [4];

    function automatic bit exp_vld(input int i);
        return !m_rs[i] && !m_fin[i] && (m_snc[i] >= gap_p[i]);
    endfunction

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (rst_i[i]) begin
                m_rs[i] = 1; m_k[i] = 0; m_snc[i] = 1000; m_fin[i] = 0;
            end else if (m_rs[i]) begin
                m_rs[i] = 0;
            end else if (exp_vld(i) && rdy[i]) begin
                if (m_k[i] == nt_p[i] + 1) m_fin[i] = 1;
                else m_k[i]++;
                m_snc[i] = 0;
            end else begin
                m_snc[i]++;
            end
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            string s;
            s = $sformatf("u%0d", i);
            chk({s, "_valid"}, 64'(vld[i]), 64'(exp_vld(i)));
            chk({s, "_done"}, 64'(dne[i]), 64'(m_fin[i]));
            if (m_rs[i])       chk({s, "_rst_data"}, 64'(dout[i]), 64'd0);
            else if (exp_vld(i)) chk({s, "_data"}, 64'(dout[i]), 64'(exp_flit(i, m_k[i])));
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst_i[i] = 1'b1; rdy[i] = 1'b0;
            m_rs[i] = 1; m_k[i] = 0; m_snc[i] = 1000; m_fin[i] = 0;
        end
        @(negedge clk);
        step();
        step();
        // Phase 1: ready always high, every instance runs to completion.
        for (int i = 0; i < 4; i++) begin rst_i[i] = 1'b0; rdy[i] = 1'b1; end
        step();
        chk("a_first_flit", 64'(dout[0]), 64'h39050000);
        for (int c = 0; c < 60; c++) step();
        for (int i = 0; i < 4; i++) chk($sformatf("u%0d_done_p1", i), 64'(dne[i]), 64'd1);

        // Phase 2: random back-pressure and occasional reset pulses.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++) begin
                rdy[i]   = ($urandom % 4) != 0;
                rst_i[i] = ($urandom % 50) == 0;
            end
            step();
        end

        // Phase 3: reset, then random ready until everyone finishes.
        for (int i = 0; i < 4; i++) rst_i[i] = 1'b1;
        step();
        for (int i = 0; i < 4; i++) rst_i[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) rdy[i] = ($urandom % 3) != 0;
            step();
        end
        for (int i = 0; i < 4; i++) chk($sformatf("u%0d_done_final", i), 64'(dne[i]), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/source.md
SOURCE -- requirements
Module: source

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning flit width in bits.
REQ-002 SHALL have parameter N, default 16, meaning number of NoC nodes (N >= 2).
REQ-003 SHALL have parameter N_ADDR_WIDTH, default $clog2(N), meaning router address width.
REQ-004 SHALL have parameter ID [7:0], default 0, meaning unique 8-bit source identifier.
REQ-005 SHALL have parameter NODE [N_ADDR_WIDTH-1:0], default 0, meaning router index this source is attached to.
REQ-006 SHALL have parameter DST_MODE, default 0, meaning 0 = fixed destination DEST, 1 = round-robin over all nodes except NODE.
REQ-007 SHALL have parameter DEST [N_ADDR_WIDTH-1:0], default 15, meaning destination used when DST_MODE=0.
REQ-008 SHALL have parameter INJ_GAP, default 0, meaning idle cycles inserted after each accepted flit.
REQ-009 SHALL have parameter NUM_TESTS, default 1000, meaning last counter value sent is NUM_TESTS+1.
REQ-010 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-011 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-012 SHALL have port done, output, 1, high once all flits are accepted.
REQ-013 SHALL have port data_out, output, WIDTH, flit payload.
REQ-014 SHALL have port valid_out, output, 1, data_out is valid.
REQ-015 SHALL have port ready_in, input, 1, downstream accepts flit this cycle.

Function
REQ-016 SHALL format data_out MSB-first: [WIDTH-1 -: N_ADDR_WIDTH] = NODE, next N_ADDR_WIDTH bits = destination, next 8 bits = ID, remaining D = WIDTH-2*N_ADDR_WIDTH-8 LSBs = data counter.
REQ-017 SHALL fail elaboration if D < 1 or NUM_TESTS+1 >= 2^D, or if DST_MODE=0 and DEST >= N.
REQ-018 SHALL register all outputs; no combinational path from ready_in to any output.
REQ-019 SHALL implement FSM states IDLE, SEND, GAP, FIN.
REQ-020 SHALL transition IDLE -> SEND on the first edge with rst low; valid_out rises on that edge.
REQ-021 SHALL count a transfer only on an edge where valid_out && ready_in.
REQ-022 SHALL hold data_out and valid_out stable while valid_out=1 and ready_in=0.
REQ-023 SHALL, on transfer of counter NUM_TESTS+1, go to FIN: valid_out=0, done=1 from that edge until reset.
REQ-024 SHALL, on any other transfer, increment counter and advance destination; if INJ_GAP=0 stay in SEND with valid_out=1 (back-to-back), else go to GAP.
REQ-025 SHALL keep valid_out=0 in GAP for exactly INJ_GAP cycles, then return to SEND with valid_out=1.
REQ-026 SHALL start destination, in DST_MODE=1, at (NODE+1) mod N and advance to next index mod N, skipping NODE; non-power-of-2 N wraps at N-1 -> 0.
REQ-027 SHALL keep destination constant at DEST in DST_MODE=0.
REQ-028 SHALL ignore ready_in in IDLE, GAP, FIN.
REQ-029 SHALL start counter at 0; first flit carries counter 0.

Reset
REQ-030 SHALL, while rst=1 at an edge, set state IDLE, valid_out=0, done=0, counter=0, destination to initial value, gap counter 0, data_out=0.
REQ-031 SHALL give rst priority over a simultaneous transfer; that transfer is discarded and not counted.
REQ-032 SHALL restart the full sequence from counter 0 after reset mid-operation or after FIN.

Verification
REQ-033 WIDTH=32,N=16,NODE=3,ID=5,DEST=9,DST_MODE=0,INJ_GAP=0,NUM_TESTS=4, ready_in=1 -> six back-to-back flits 0x39050000..0x39050005, then valid_out=0, done=1.
REQ-034 Same config, ready_in=0 for 3 cycles while flit counter=2 is valid -> data_out=0x39050002 held 3 cycles, sent once, sequence continues at 3.
REQ-035 INJ_GAP=2, ready_in=1 -> valid_out pattern 1,0,0,1,0,0,...; six flits total; done after sixth.
REQ-036 DST_MODE=1, N=16, NODE=15, NUM_TESTS=20 -> destinations 0,1,...,14,0,1,...,6; 15 never appears.
REQ-037 N=5 (N_ADDR_WIDTH=3), NODE=2, DST_MODE=1 -> destinations 3,4,0,1,3,4,...
REQ-038 rst pulsed 1 cycle with valid_out=1, ready_in=1, counter=3 -> next cycle valid_out=0, done=0; following cycle flit counter 0 reappears.
